blwl_prog_sequencer: RTL and testbench
======================================

# blwl_prog_sequencer

Synthesizable bit-line/word-line programming sequencer for memory-bank configured logic blocks. It accepts one configuration row per handshake and drives the row onto `bl` with a one-hot `wl` select. It generates the `prog_EN`/`prog_ENb` write pulse with programmable setup and pulse widths, and raises `config_done` after the last row. It sits between the configuration loader and the fabric BL/WL ports. It generalises the fixed one-hot BL rotation used in logic-block benches to arbitrary array sizes and timing.

## Interface
Parameters:
- `NUM_BL`, 32, bit-lines per row (≥1)
- `NUM_WL`, 16, word-lines, i.e. rows programmed per sequence (≥2)
- `SETUP_CYCLES`, 1, cycles BL/WL are stable before the pulse (≥1)
- `PULSE_CYCLES`, 2, width of `prog_EN` high (≥1)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `Reset`  in  1  synchronous, active-high; wins over every other input
- `start`  in  1  begin a sequence; honoured only in IDLE or DONE
- `cfg_data`  in  NUM_BL  row contents for the current row
- `cfg_valid`  in  1  `cfg_data` valid
- `cfg_ready`  out  1  sequencer accepts a row this cycle
- `bl`  out  NUM_BL  bit-line drive
- `wl`  out  NUM_WL  word-line select, one-hot or zero
- `prog_EN`  out  1  write pulse
- `prog_ENb`  out  1  always `~prog_EN`
- `row_idx`  out  $clog2(NUM_WL)  row currently loaded or programmed
- `busy`  out  1  high in LOAD, SETUP, PULSE and HOLD
- `config_done`  out  1  all NUM_WL rows programmed

## Operation
- FSM states: IDLE, LOAD, SETUP, PULSE, HOLD, DONE. All outputs are registered.
- **IDLE / DONE:**
  - On `start`, clear `config_done`, set `row_idx=0`, and go to LOAD.
- **LOAD:**
  - `cfg_ready=1`.
  - On `cfg_valid&cfg_ready`, latch `cfg_data` into `bl`, set `wl[row_idx]=1`, and go to SETUP.
  - Without valid, wait indefinitely with `bl=0` and `wl=0`.
- **SETUP:**
  - Hold for SETUP_CYCLES with `prog_EN=0`, then go to PULSE.
- **PULSE:**
  - `prog_EN=1` for PULSE_CYCLES, then go to HOLD.
- **HOLD:**
  - One cycle with `prog_EN=0` and `bl`/`wl` unchanged.
  - Then clear `bl` and `wl`.
  - If `row_idx==NUM_WL-1`, go to DONE and set `config_done=1`.
  - Otherwise increment `row_idx` and go to LOAD.
- `bl` and `wl` are nonzero only in SETUP, PULSE and HOLD. `wl` never has more than one bit set.
- `config_done` stays high in DONE until `start` or `Reset`.
- `start` while `busy` is ignored. `cfg_valid` outside LOAD is ignored and the data is not consumed.
- Reset values: `bl=0`, `wl=0`, `prog_EN=0`, `prog_ENb=1`, `cfg_ready=0`, `busy=0`, `config_done=0`, `row_idx=0`, state=IDLE.
- `Reset` mid-sequence aborts immediately to the reset values on the next edge. A partially programmed row is not resumed.

## Timing
- `start` sampled at edge S: `cfg_ready`, `busy`=1 from S+1.
- Handshake at edge T: `bl`/`wl` valid from T+1.
  - `prog_EN` high for cycles T+1+SETUP_CYCLES through T+SETUP_CYCLES+PULSE_CYCLES.
  - HOLD cycle follows.
  - Next `cfg_ready` one cycle after HOLD.
- Row period with `cfg_valid` held high: 2+SETUP_CYCLES+PULSE_CYCLES cycles. The default is 5 cycles, 80 cycles for the full sequence.
- `config_done` and `busy=0` occur on the edge ending the last HOLD.
- `prog_EN` and `prog_ENb` toggle on the same edge. `bl`/`wl` never change while `prog_EN=1`.

## Structure
- Package `blwl_pkg`: FSM state enum and a `ROW_W` localparam helper (clog2 wrapper).
- Counters:
  - one shared phase counter of width clog2(max(SETUP_CYCLES,PULSE_CYCLES)+1), reloaded on state entry
  - one row counter
- Sub-module `blwl_onehot_dec`: (`row_idx`, `en`) to `wl`. It is combinational and registered in the parent.

## Test plan
- Defaults, 16 rows with `cfg_data=32'h1<<row`, `cfg_valid` always high, `start` pulsed once:
  - 16 `prog_EN` pulses, each 2 cycles wide, with `wl` one-hot matching `row_idx`
  - `config_done` at cycle 81 after `start`
- Insert 3 idle `cfg_valid` cycles before row 5:
  - `cfg_ready` held, with `bl=0` and `wl=0` during the gap
  - row 5 then programmed normally and total latency +3
- Assert `Reset` during PULSE of row 7:
  - next cycle shows all outputs at reset values
  - a subsequent `start` reprograms from row 0
- `start` during row 2 of a sequence: ignored, `row_idx` continues to 15.
- After DONE, pulse `start`:
  - `config_done` drops on the next edge
  - a second full sequence completes identically
- Parameters NUM_BL=8, NUM_WL=4, SETUP_CYCLES=3, PULSE_CYCLES=1:
  - row period 6 cycles
  - `bl` stable 3 cycles before and 1 after each 1-cycle `prog_EN`

Source files
------------

// File: rtl/blwl_pkg.sv
// Shared types and width helpers for the BL/WL programming sequencer.
package blwl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    // $clog2 that never returns zero, so 1-entry ranges still get a bit.
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int row_w(input int num_wl);
        return clog2w(num_wl);
    endfunction

    function automatic int phase_w(input int setup, input int pulse);
        return clog2w(((setup > pulse) ? setup : pulse) + 1);
    endfunction

endpackage

// File: rtl/blwl_onehot_dec.sv
// Row index to one-hot word-line select; all zero when disabled.
module blwl_onehot_dec #(
    parameter int NUM_WL = 16,
    parameter int ROW_W  = 4
) (
    input  logic [ROW_W-1:0]  i_idx,
    input  logic              i_en,
    output logic [NUM_WL-1:0] o_wl
);

    always_comb begin
        o_wl = '0;
        for (int i = 0; i < NUM_WL; i++) begin
            if (i_en && (i_idx == ROW_W'(i))) begin
                o_wl[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/blwl_prog_sequencer.sv
// Row-at-a-time BL/WL programming sequencer with setup/pulse/hold
// timing around a registered prog_EN write strobe.
module blwl_prog_sequencer
    import blwl_pkg::*;
#(
    parameter int NUM_BL       = 32,
    parameter int NUM_WL       = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       start,
    input  logic [NUM_BL-1:0]          cfg_data,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    output logic [NUM_BL-1:0]          bl,
    output logic [NUM_WL-1:0]          wl,
    output logic                       prog_EN,
    output logic                       prog_ENb,
    output logic [row_w(NUM_WL)-1:0]   row_idx,
    output logic                       busy,
    output logic                       config_done
);

    localparam int ROW_W = row_w(NUM_WL);
    localparam int PH_W  = phase_w(SETUP_CYCLES, PULSE_CYCLES);

    state_t              r_state;
    logic [PH_W-1:0]     r_phase;
    logic [ROW_W-1:0]    r_row;
    logic [NUM_BL-1:0]   r_bl;
    logic [NUM_WL-1:0]   r_wl;
    logic                r_prog_en;
    logic                r_cfg_ready;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [ROW_W-1:0]    w_row_nxt;
    logic [NUM_BL-1:0]   w_bl_nxt;
    logic [NUM_WL-1:0]   w_wl_nxt;
    logic                w_done_nxt;
    logic                w_accept;
    logic [NUM_WL-1:0]   w_dec_wl;

    assign w_accept = (r_state == S_LOAD) && cfg_valid;

    blwl_onehot_dec #(
        .NUM_WL (NUM_WL),
        .ROW_W  (ROW_W)
    ) u_dec (
        .i_idx  (r_row),
        .i_en   (w_accept),
        .o_wl   (w_dec_wl)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_row_nxt   = r_row;
        w_bl_nxt    = r_bl;
        w_wl_nxt    = r_wl;
        w_done_nxt  = r_done;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_row_nxt   = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_bl_nxt    = cfg_data;
                    w_wl_nxt    = w_dec_wl;
                    w_phase_nxt = PH_W'(SETUP_CYCLES - 1);
                end
            end
            S_SETUP: begin
                if (r_phase == '0) begin
                    w_state_nxt = S_PULSE;
                    w_phase_nxt = PH_W'(PULSE_CYCLES - 1);
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            S_PULSE: begin
                if (r_phase == '0) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            S_HOLD: begin
                w_bl_nxt = '0;
                w_wl_nxt = '0;
                if (r_row == ROW_W'(NUM_WL - 1)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_LOAD;
                    w_row_nxt   = r_row + ROW_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_row       <= '0;
            r_bl        <= '0;
            r_wl        <= '0;
            r_prog_en   <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_row       <= w_row_nxt;
            r_bl        <= w_bl_nxt;
            r_wl        <= w_wl_nxt;
            r_prog_en   <= (w_state_nxt == S_PULSE);
            r_cfg_ready <= (w_state_nxt == S_LOAD);
            r_busy      <= (w_state_nxt == S_LOAD)  ||
                           (w_state_nxt == S_SETUP) ||
                           (w_state_nxt == S_PULSE) ||
                           (w_state_nxt == S_HOLD);
            r_done      <= w_done_nxt;
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign bl          = r_bl;
    assign wl          = r_wl;
    assign prog_EN     = r_prog_en;
    assign prog_ENb    = ~r_prog_en;
    assign row_idx     = r_row;
    assign busy        = r_busy;
    assign config_done = r_done;

endmodule

// File: tb/tb_blwl_prog_sequencer.sv
// Randomized bench for two sequencer configurations against a
// row-timing reference model.
module tb_blwl_prog_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, st0, vl0;
    logic [31:0] d0;
    logic        rdy0, en0, enb0, busy0, done0;
    logic [31:0] bl0;
    logic [15:0] wl0;
    logic [3:0]  row0;

    logic        rst1, st1, vl1;
    logic [7:0]  d1;
    logic        rdy1, en1, enb1, busy1, done1;
    logic [7:0]  bl1;
    logic [3:0]  wl1;
    logic [1:0]  row1;

    blwl_prog_sequencer dut0 (
        .clk         (clk),
        .Reset       (rst0),
        .start       (st0),
        .cfg_data    (d0),
        .cfg_valid   (vl0),
        .cfg_ready   (rdy0),
        .bl          (bl0),
        .wl          (wl0),
        .prog_EN     (en0),
        .prog_ENb    (enb0),
        .row_idx     (row0),
        .busy        (busy0),
        .config_done (done0)
    );

    blwl_prog_sequencer #(
        .NUM_BL       (8),
        .NUM_WL       (4),
        .SETUP_CYCLES (3),
        .PULSE_CYCLES (1)
    ) dut1 (
        .clk         (clk),
        .Reset       (rst1),
        .start       (st1),
        .cfg_data    (d1),
        .cfg_valid   (vl1),
        .cfg_ready   (rdy1),
        .bl          (bl1),
        .wl          (wl1),
        .prog_EN     (en1),
        .prog_ENb    (enb1),
        .row_idx     (row1),
        .busy        (busy1),
        .config_done (done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: a sequence is running or not; ph counts cycles since
    // the row handshake (0 = waiting for a row).
    int          m_run[2], m_done[2], m_row[2], m_ph[2];
    logic [31:0] m_dat[2];

    function automatic int nwl(input int i); return (i == 0) ? 16 : 4; endfunction
    function automatic int sc(input int i);  return (i == 0) ? 1 : 3;  endfunction
    function automatic int pc(input int i);  return (i == 0) ? 2 : 1;  endfunction

    task automatic model_step(input int i, input logic r, input logic s,
                              input logic v, input logic [31:0] d);
        if (r) begin
            m_run[i] = 0; m_done[i] = 0; m_row[i] = 0; m_ph[i] = 0;
        end else if (m_run[i] == 0) begin
            if (s) begin
                m_run[i] = 1; m_done[i] = 0; m_row[i] = 0; m_ph[i] = 0;
            end
        end else if (m_ph[i] == 0) begin
            if (v) begin
                m_dat[i] = d; m_ph[i] = 1;
            end
        end else if (m_ph[i] == sc(i) + pc(i) + 1) begin
            if (m_row[i] == nwl(i) - 1) begin
                m_run[i] = 0; m_done[i] = 1;
            end else begin
                m_row[i]++; m_ph[i] = 0;
            end
        end else begin
            m_ph[i]++;
        end
    endtask

    task automatic compare(input int i, input logic [31:0] bl,
                           input logic [31:0] wl, input logic en,
                           input logic enb, input logic rdy,
                           input logic [31:0] row, input logic busy,
                           input logic done);
        logic        act;
        logic        e_en;
        logic [31:0] one;
        act  = (m_run[i] != 0) && (m_ph[i] > 0);
        e_en = (m_run[i] != 0) && (m_ph[i] >= sc(i) + 1) &&
               (m_ph[i] <= sc(i) + pc(i));
        one  = 32'h1;
        check($sformatf("u%0d.bl", i), bl, act ? m_dat[i] : 32'h0);
        check($sformatf("u%0d.wl", i), wl, act ? (one << m_row[i]) : 32'h0);
        check($sformatf("u%0d.prog_EN", i), {31'h0, en}, {31'h0, e_en});
        check($sformatf("u%0d.prog_ENb", i), {31'h0, enb}, {31'h0, ~e_en});
        check($sformatf("u%0d.cfg_ready", i), {31'h0, rdy},
              {31'h0, (m_run[i] != 0) && (m_ph[i] == 0)});
        check($sformatf("u%0d.row_idx", i), row, m_row[i]);
        check($sformatf("u%0d.busy", i), {31'h0, busy}, {31'h0, m_run[i] != 0});
        check($sformatf("u%0d.config_done", i), {31'h0, done},
              {31'h0, m_done[i] != 0});
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, rst0, st0, vl0, d0);
        model_step(1, rst1, st1, vl1, {24'h0, d1});
        #1;
        compare(0, bl0, {16'h0, wl0}, en0, enb0, rdy0, {28'h0, row0},
                busy0, done0);
        compare(1, {24'h0, bl1}, {28'h0, wl1}, en1, enb1, rdy1,
                {30'h0, row1}, busy1, done1);
    endtask

    int   n, pulses, gap, last_rise, hit;
    logic prev_en;
    logic [31:0] one32;

    initial begin
        rst0 = 1'b1; st0 = 1'b0; vl0 = 1'b0; d0 = '0;
        rst1 = 1'b1; st1 = 1'b0; vl1 = 1'b0; d1 = '0;
        one32 = 32'h1;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_done[i] = 0; m_row[i] = 0; m_ph[i] = 0;
            m_dat[i] = '0;
        end
        step();
        step();
        rst0 = 1'b0; rst1 = 1'b0;
        step();

        // Full default sequence, valid always high, walking-one data.
        st0 = 1'b1; step(); st0 = 1'b0;
        vl0 = 1'b1; n = 0; pulses = 0; prev_en = 1'b0;
        while (!done0 && n < 300) begin
            d0 = one32 << m_row[0];
            step(); n++;
            if (en0 && !prev_en) pulses++;
            prev_en = en0;
        end
        check("lat_full", n, 80);
        check("pulses_full", pulses, 16);
        repeat (3) step();

        // Restart from DONE, 3-cycle valid gap at row 5, start at row 2.
        st0 = 1'b1; step(); st0 = 1'b0;
        check("done_drop", {31'h0, done0}, 32'h0);
        n = 0; gap = 0;
        while (!done0 && n < 300) begin
            vl0 = 1'b1;
            if (m_row[0] == 5 && m_ph[0] == 0 && gap < 3) begin
                vl0 = 1'b0; gap++;
            end
            st0 = (m_row[0] == 2) && (m_ph[0] == 2);
            d0 = $urandom;
            step(); n++;
        end
        st0 = 1'b0;
        check("lat_gap", n, 83);
        check("row_end", {28'h0, row0}, 32'd15);

        // Random valid/start, Reset during the PULSE of row 7.
        st0 = 1'b1; step(); st0 = 1'b0;
        n = 0; hit = 0;
        while (hit == 0 && n < 1000) begin
            vl0 = ($urandom_range(0, 3) != 0);
            d0  = $urandom;
            st0 = ($urandom_range(0, 7) == 0);
            rst0 = (m_row[0] == 7) && (m_ph[0] == 2);
            if (rst0) hit = 1;
            step(); n++;
        end
        rst0 = 1'b0; st0 = 1'b0;
        check("rst_hit", hit, 1);
        check("rst_busy", {31'h0, busy0}, 32'h0);
        check("rst_row", {28'h0, row0}, 32'h0);
        st0 = 1'b1; step(); st0 = 1'b0;
        n = 0;
        while (!done0 && n < 1000) begin
            vl0 = ($urandom_range(0, 2) != 0);
            d0  = $urandom;
            st0 = ($urandom_range(0, 9) == 0);
            step(); n++;
        end
        st0 = 1'b0; vl0 = 1'b0;
        check("rerun_done", {31'h0, done0}, 32'h1);

        // Small configuration: 6-cycle row period, 24-cycle sequence.
        st1 = 1'b1; step(); st1 = 1'b0;
        vl1 = 1'b1; n = 0; last_rise = -1; prev_en = 1'b0;
        while (!done1 && n < 200) begin
            d1 = 8'($urandom);
            step(); n++;
            if (en1 && !prev_en) begin
                if (last_rise >= 0) check("period_small", n - last_rise, 6);
                last_rise = n;
            end
            prev_en = en1;
        end
        check("lat_small", n, 24);
        st1 = 1'b1; step(); st1 = 1'b0;
        n = 0;
        while (!done1 && n < 500) begin
            vl1 = $urandom_range(0, 1) != 0;
            d1  = 8'($urandom);
            step(); n++;
        end
        check("small_rand_done", {31'h0, done1}, 32'h1);
        vl1 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
